// File: rtl/microaddr_pkg.sv
// Shared types for the Z-Machine microaddress sequencer: the sequencing
// command encoding and the default microaddress width.
package microaddr;

   localparam int DEFAULT_AW = 11;

   typedef enum logic [2:0] {
      NEXT     = 3'd0,
      JUMP     = 3'd1,
      BRANCH   = 3'd2,
      DISPATCH = 3'd3,
      CALL     = 3'd4,
      RETURN   = 3'd5,
      HOLD     = 3'd6
   } cmd_t;

endpackage

// File: rtl/microaddr_stack.sv
// LIFO return-address stack for the microsequencer: register array plus a
// single pointer. Overflow/underflow policy is left to the parent.
module microaddr_stack #(
   parameter int AW    = 11,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic                         pop,
   input  logic [AW-1:0]                push_data,
   output logic [AW-1:0]                top,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   depth
);

   localparam int PW    = $clog2(DEPTH + 1);
   localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int SLOTS = 1 << IW;

   logic [AW-1:0] mem_reg [SLOTS];
   logic [PW-1:0] ptr_reg;
   logic [PW-1:0] ptr_dec;
   logic [IW-1:0] wr_idx;
   logic [IW-1:0] rd_idx;

   assign ptr_dec = ptr_reg - PW'(1);
   assign wr_idx  = ptr_reg[IW-1:0];
   assign rd_idx  = ptr_dec[IW-1:0];

   assign full  = (ptr_reg == PW'(DEPTH));
   assign empty = (ptr_reg == '0);
   assign depth = ptr_reg;
   assign top   = mem_reg[rd_idx];

   // Contents are don't-care after reset, so only the pointer is cleared.
   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem_reg[wr_idx] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_reg <= '0;
      end else if (push && !full) begin
         ptr_reg <= ptr_reg + PW'(1);
      end else if (pop && !empty) begin
         ptr_reg <= ptr_dec;
      end
   end

endmodule

// File: rtl/microaddr_sequencer.sv
// Microprogram address generator: next/jump/branch/dispatch sequencing with a
// hardware call/return stack, stall, and sticky halting fault flags.
module microaddr_sequencer
   import microaddr::*;
#(
   parameter int              AW         = DEFAULT_AW,
   parameter int              DEPTH      = 4,
   parameter logic [AW-1:0]   RESET_ADDR = '0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         stall,
   input  logic [2:0]                   cmd,
   input  logic                         cond,
   input  logic [AW-1:0]                load_addr,
   input  logic [AW-1:0]                dispatch_addr,
   output logic [AW-1:0]                addr,
   output logic [$clog2(DEPTH+1)-1:0]   depth,
   output logic                         overflow,
   output logic                         underflow
);

   cmd_t          cmd_sel;
   logic [AW-1:0] addr_reg, addr_next;
   logic [AW-1:0] inc;
   logic [AW-1:0] stack_top;
   logic          overflow_reg, overflow_next;
   logic          underflow_reg, underflow_next;
   logic          push, pop;
   logic          stack_full, stack_empty;
   logic          fault;

   assign cmd_sel = cmd_t'(cmd);
   assign inc     = addr_reg + AW'(1);
   assign fault   = overflow_reg | underflow_reg;

   microaddr_stack #(
      .AW    (AW),
      .DEPTH (DEPTH)
   ) u_stack (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .push_data (inc),
      .top       (stack_top),
      .full      (stack_full),
      .empty     (stack_empty),
      .depth     (depth)
   );

   // A fault halts sequencing until reset; stall freezes everything for a cycle.
   always_comb begin
      addr_next      = addr_reg;
      overflow_next  = overflow_reg;
      underflow_next = underflow_reg;
      push           = 1'b0;
      pop            = 1'b0;
      if (!stall && !fault) begin
         unique case (cmd_sel)
            NEXT:     addr_next = inc;
            JUMP:     addr_next = load_addr;
            BRANCH:   addr_next = cond ? load_addr : inc;
            DISPATCH: addr_next = dispatch_addr;
            CALL: begin
               if (stack_full) begin
                  overflow_next = 1'b1;
               end else begin
                  push      = 1'b1;
                  addr_next = load_addr;
               end
            end
            RETURN: begin
               if (stack_empty) begin
                  underflow_next = 1'b1;
               end else begin
                  pop       = 1'b1;
                  addr_next = stack_top;
               end
            end
            HOLD:     addr_next = addr_reg;
            default:  addr_next = addr_reg;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_reg      <= RESET_ADDR;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         addr_reg      <= addr_next;
         overflow_reg  <= overflow_next;
         underflow_reg <= underflow_next;
      end
   end

   assign addr      = addr_reg;
   assign overflow  = overflow_reg;
   assign underflow = underflow_reg;

endmodule

// File: tb/tb_microaddr_sequencer.sv
// Self-checking bench for microaddr_sequencer: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_microaddr_sequencer;

   localparam int            AW         = 11;
   localparam int            DEPTH      = 4;
   localparam int            DW         = $clog2(DEPTH + 1);
   localparam logic [AW-1:0] RESET_ADDR = '0;

   localparam logic [2:0] C_NEXT = 3'd0, C_JUMP = 3'd1, C_BRANCH = 3'd2, C_DISPATCH = 3'd3;
   localparam logic [2:0] C_CALL = 3'd4, C_RETURN = 3'd5, C_HOLD = 3'd6;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          stall = 1'b0;
   logic [2:0]    cmd = 3'd0;
   logic          cond = 1'b0;
   logic [AW-1:0] load_addr = '0;
   logic [AW-1:0] dispatch_addr = '0;
   logic [AW-1:0] addr;
   logic [DW-1:0] depth;
   logic          overflow;
   logic          underflow;

   // Reference model: a plain queue as the call stack
   logic [AW-1:0] m_addr;
   logic [AW-1:0] m_stack [$];
   logic          m_ovf, m_unf;

   int n_checks = 0;
   int n_fail   = 0;

   microaddr_sequencer #(
      .AW         (AW),
      .DEPTH      (DEPTH),
      .RESET_ADDR (RESET_ADDR)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .cmd           (cmd),
      .cond          (cond),
      .load_addr     (load_addr),
      .dispatch_addr (dispatch_addr),
      .addr          (addr),
      .depth         (depth),
      .overflow      (overflow),
      .underflow     (underflow)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      m_addr = RESET_ADDR;
      m_stack.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endfunction

   // Present one command, clock it, advance the model, sample 1 time unit later.
   task automatic cycle(input logic s, input logic [2:0] c, input logic cd,
                        input logic [AW-1:0] la, input logic [AW-1:0] da);
      logic [AW-1:0] nxt;
      stall = s; cmd = c; cond = cd; load_addr = la; dispatch_addr = da;
      @(posedge clk);
      nxt = m_addr + 1'b1;
      if (!s && !(m_ovf || m_unf)) begin
         case (c)
            C_NEXT:     m_addr = nxt;
            C_JUMP:     m_addr = la;
            C_BRANCH:   m_addr = cd ? la : nxt;
            C_DISPATCH: m_addr = da;
            C_CALL: begin
               if (m_stack.size() < DEPTH) begin
                  m_stack.push_back(nxt);
                  m_addr = la;
               end else begin
                  m_ovf = 1'b1;
               end
            end
            C_RETURN: begin
               if (m_stack.size() > 0) m_addr = m_stack.pop_back();
               else m_unf = 1'b1;
            end
            default: ;
         endcase
      end
      #1;
      $display("txn stall=%0b cmd=%0d cond=%0b load=%03h disp=%03h -> addr=%03h depth=%0d ovf=%0b unf=%0b",
               s, c, cd, la, da, addr, depth, overflow, underflow);
   endtask

   // Reset asserted between clock edges; caller checks, then releases.
   task automatic assert_reset();
      #2;
      reset = 1'b0;
      model_reset();
      #1;
   endtask

   task automatic release_reset();
      #1;
      reset = 1'b1;
   endtask

   task automatic test_reset();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (addr !== RESET_ADDR) begin n_fail++; $display("FAIL reset_addr got=%03h exp=%03h", addr, RESET_ADDR); end
      n_checks++; if (depth !== DW'(0)) begin n_fail++; $display("FAIL reset_depth got=%0d exp=0", depth); end
      n_checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL reset_flags got=%0b%0b exp=00", overflow, underflow); end
      release_reset();
   endtask

   task automatic test_next_wrap();
      for (int i = 1; i <= 3; i++) begin
         cycle(1'b0, C_NEXT, 1'b0, '0, '0);
         n_checks++; if (addr !== AW'(i)) begin n_fail++; $display("FAIL next_seq got=%03h exp=%03h", addr, AW'(i)); end
      end
      cycle(1'b0, C_JUMP, 1'b0, 11'h7FF, '0);
      n_checks++; if (addr !== 11'h7FF) begin n_fail++; $display("FAIL jump_7ff got=%03h exp=7ff", addr); end
      cycle(1'b0, C_NEXT, 1'b0, '0, '0);
      n_checks++; if (addr !== 11'h000) begin n_fail++; $display("FAIL wrap got=%03h exp=000", addr); end
      n_checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL wrap_flags got=%0b%0b exp=00", overflow, underflow); end
   endtask

   task automatic test_branch();
      cycle(1'b0, C_JUMP, 1'b0, 11'h010, '0);
      cycle(1'b0, C_BRANCH, 1'b0, 11'h100, '0);
      n_checks++; if (addr !== 11'h011) begin n_fail++; $display("FAIL branch_nt got=%03h exp=011", addr); end
      cycle(1'b0, C_BRANCH, 1'b1, 11'h100, '0);
      n_checks++; if (addr !== 11'h100) begin n_fail++; $display("FAIL branch_t got=%03h exp=100", addr); end
   endtask

   task automatic test_nested_call();
      cycle(1'b0, C_JUMP, 1'b0, 11'h020, '0);
      cycle(1'b0, C_CALL, 1'b0, 11'h200, '0);
      n_checks++; if (addr !== 11'h200 || depth !== DW'(1)) begin n_fail++; $display("FAIL call1 got=%03h/%0d exp=200/1", addr, depth); end
      cycle(1'b0, C_CALL, 1'b0, 11'h300, '0);
      n_checks++; if (addr !== 11'h300 || depth !== DW'(2)) begin n_fail++; $display("FAIL call2 got=%03h/%0d exp=300/2", addr, depth); end
      cycle(1'b0, C_RETURN, 1'b0, 11'h6EE, '0);
      n_checks++; if (addr !== 11'h201 || depth !== DW'(1)) begin n_fail++; $display("FAIL ret1 got=%03h/%0d exp=201/1", addr, depth); end
      cycle(1'b0, C_RETURN, 1'b0, 11'h5DD, '0);
      n_checks++; if (addr !== 11'h021 || depth !== DW'(0)) begin n_fail++; $display("FAIL ret2 got=%03h/%0d exp=021/0", addr, depth); end
      // call immediately followed by return, load_addr changed in between
      cycle(1'b0, C_CALL, 1'b0, 11'h2F0, '0);
      cycle(1'b0, C_RETURN, 1'b0, 11'h7AA, '0);
      n_checks++; if (addr !== 11'h022 || depth !== DW'(0)) begin n_fail++; $display("FAIL call_ret got=%03h/%0d exp=022/0", addr, depth); end
   endtask

   task automatic test_overflow();
      cycle(1'b0, C_JUMP, 1'b0, 11'h040, '0);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, C_CALL, 1'b0, AW'(11'h400 + i * 16), '0);
      end
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got=%0b exp=1", overflow); end
      n_checks++; if (addr !== 11'h430 || depth !== DW'(DEPTH)) begin n_fail++; $display("FAIL ovf_state got=%03h/%0d exp=430/4", addr, depth); end
      cycle(1'b0, C_NEXT, 1'b0, '0, '0);
      cycle(1'b0, C_JUMP, 1'b0, 11'h123, '0);
      cycle(1'b0, C_RETURN, 1'b0, '0, '0);
      n_checks++; if (addr !== 11'h430 || depth !== DW'(DEPTH)) begin n_fail++; $display("FAIL ovf_frozen got=%03h/%0d exp=430/4", addr, depth); end
      assert_reset();
      n_checks++; if (addr !== RESET_ADDR || overflow !== 1'b0 || depth !== DW'(0)) begin n_fail++; $display("FAIL ovf_reset got=%03h/%0b/%0d exp=000/0/0", addr, overflow, depth); end
      release_reset();
   endtask

   task automatic test_underflow_stall();
      cycle(1'b0, C_JUMP, 1'b0, 11'h030, '0);
      cycle(1'b1, C_CALL, 1'b0, 11'h3AA, '0);
      n_checks++; if (addr !== 11'h030 || depth !== DW'(0)) begin n_fail++; $display("FAIL stall_call got=%03h/%0d exp=030/0", addr, depth); end
      cycle(1'b0, C_CALL, 1'b0, 11'h3AA, '0);
      cycle(1'b1, C_RETURN, 1'b0, '0, '0);
      n_checks++; if (addr !== 11'h3AA || depth !== DW'(1)) begin n_fail++; $display("FAIL stall_ret got=%03h/%0d exp=3aa/1", addr, depth); end
      cycle(1'b0, C_RETURN, 1'b0, '0, '0);
      n_checks++; if (addr !== 11'h031 || depth !== DW'(0)) begin n_fail++; $display("FAIL ret_after_stall got=%03h/%0d exp=031/0", addr, depth); end
      cycle(1'b0, C_RETURN, 1'b0, '0, '0);
      n_checks++; if (underflow !== 1'b1 || overflow !== 1'b0 || addr !== 11'h031) begin n_fail++; $display("FAIL unf got=%0b%0b/%03h exp=01/031", overflow, underflow, addr); end
      cycle(1'b0, C_NEXT, 1'b0, '0, '0);
      cycle(1'b0, C_DISPATCH, 1'b0, '0, 11'h0AB);
      n_checks++; if (addr !== 11'h031) begin n_fail++; $display("FAIL unf_halt got=%03h exp=031", addr); end
      assert_reset();
      n_checks++; if (underflow !== 1'b0 || addr !== RESET_ADDR) begin n_fail++; $display("FAIL unf_reset got=%0b/%03h exp=0/000", underflow, addr); end
      release_reset();
   endtask

   task automatic test_async_reset();
      cycle(1'b0, C_JUMP, 1'b0, 11'h050, '0);
      for (int i = 0; i < 3; i++) cycle(1'b0, C_CALL, 1'b0, AW'(11'h500 + i * 32), '0);
      n_checks++; if (depth !== DW'(3)) begin n_fail++; $display("FAIL depth3 got=%0d exp=3", depth); end
      assert_reset();
      n_checks++; if (addr !== RESET_ADDR || depth !== DW'(0)) begin n_fail++; $display("FAIL async_reset got=%03h/%0d exp=000/0", addr, depth); end
      release_reset();
      cycle(1'b0, C_DISPATCH, 1'b0, 11'h7FF, 11'h155);
      n_checks++; if (addr !== 11'h155 || depth !== DW'(0)) begin n_fail++; $display("FAIL dispatch got=%03h/%0d exp=155/0", addr, depth); end
      cycle(1'b0, C_RETURN, 1'b0, '0, '0);
      n_checks++; if (underflow !== 1'b1 || addr !== 11'h155) begin n_fail++; $display("FAIL stack_discarded got=%0b/%03h exp=1/155", underflow, addr); end
      assert_reset();
      release_reset();
   endtask

   task automatic test_random();
      logic [2:0] c;
      for (int i = 0; i < 400; i++) begin
         if ((m_ovf || m_unf) && $urandom_range(0, 2) == 0) begin
            assert_reset();
            release_reset();
         end
         c = 3'($urandom_range(0, 7));
         cycle(($urandom_range(0, 7) == 0), c, 1'($urandom_range(0, 1)),
               AW'($urandom), AW'($urandom));
         n_checks++; if (addr !== m_addr) begin n_fail++; $display("FAIL rand_addr i=%0d got=%03h exp=%03h", i, addr, m_addr); end
         n_checks++; if (depth !== DW'(m_stack.size())) begin n_fail++; $display("FAIL rand_depth i=%0d got=%0d exp=%0d", i, depth, m_stack.size()); end
         n_checks++; if (overflow !== m_ovf || underflow !== m_unf) begin n_fail++; $display("FAIL rand_flags i=%0d got=%0b%0b exp=%0b%0b", i, overflow, underflow, m_ovf, m_unf); end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_next_wrap();
      test_branch();
      test_nested_call();
      test_overflow();
      test_underflow_stall();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
